// File: rtl/outport_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : outport_arbiter_pkg
//  Description : Shared flit-format constants, FSM state encoding and index
//                helpers for the NoC output-port arbiter.
//                DATAWIDTH / SENDBIT / NEXTHOPWIDTH describe the flit layout;
//                TAIL_BIT is the position of the tail marker inside a flit.
//  Revision    : 1.0 - initial release
// ============================================================================
package outport_arbiter_pkg;

   localparam int DATAWIDTH    = 32;
   localparam int SENDBIT      = 1;
   localparam int NEXTHOPWIDTH = 3;
   localparam int TAIL_BIT     = DATAWIDTH + SENDBIT - 1;

   // Wormhole lock state: IDLE arbitrates, LOCKED follows one owner.
   typedef enum logic [0:0] {
      ST_IDLE   = 1'b0,
      ST_LOCKED = 1'b1
   } arb_state_t;

   // idx + 1, wrapping to 0 at n.
   function automatic int wrap_inc(input int idx, input int n);
      return (idx + 1 >= n) ? 0 : idx + 1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/outport_arbiter_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arbiter
//  Description : Combinational round-robin picker. Scans req starting at
//                ptr, wrapping at N, and returns the first requester.
//  Ports       : req       [N]     request vector
//                ptr       [IDX_W] scan start index (must be < N)
//                win_oh    [N]     one-hot winner (0 when nobody requests)
//                win_idx   [IDX_W] winner index
//                win_valid         some requester was found
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
   parameter int N     = 5,
   parameter int IDX_W = $clog2(N)
) (
   input  logic [N-1:0]     req,
   input  logic [IDX_W-1:0] ptr,
   output logic [N-1:0]     win_oh,
   output logic [IDX_W-1:0] win_idx,
   output logic             win_valid
);

   logic [IDX_W-1:0] w_cand;

   always_comb begin
      win_oh    = '0;
      win_idx   = '0;
      win_valid = 1'b0;
      w_cand    = '0;
      for (int k = 0; k < N; k++) begin
         w_cand = IDX_W'((int'(ptr) + k) % N);
         if (!win_valid && req[w_cand]) begin
            win_valid      = 1'b1;
            win_idx        = w_cand;
            win_oh[w_cand] = 1'b1;
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/outport_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : outport_arbiter
//  Description : NoC router output-port stage. Round-robin arbitration among
//                NUM_IN inputs with a wormhole lock held until the packet
//                tail, a registered flit output and a downstream credit
//                counter that gates every accept.
//  Option      : `OUTARB_OVERRIDE_EN adds the override_oth port; in IDLE the
//                lowest index of override_oth & req wins ahead of round-robin.
//  Ports       : clk, rst            clock, synchronous active-high reset
//                req/tail  [NUM_IN]  flit pending / pending flit is a tail
//                iput [NUM_IN*DATA_W] flits, input i at [i*DATA_W +: DATA_W]
//                grant     [NUM_IN]  one-hot, input's flit consumed now
//                q [DATA_W], send    registered flit and its valid
//                credit_ret          downstream freed one slot
//                override_oth        priority requests (option only)
//                credits   [CNT_W]   current credit count
//  Revision    : 1.0 - initial release
// ============================================================================
module outport_arbiter
   import outport_arbiter_pkg::*;
#(
   parameter int NUM_IN  = 5,
   parameter int DATA_W  = DATAWIDTH + SENDBIT,
   parameter int CREDITS = 4,
   parameter int CNT_W   = $clog2(CREDITS + 1)
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [NUM_IN-1:0]        req,
   input  logic [NUM_IN-1:0]        tail,
   input  logic [NUM_IN*DATA_W-1:0] iput,
   output logic [NUM_IN-1:0]        grant,
   output logic [DATA_W-1:0]        q,
   output logic                     send,
   input  logic                     credit_ret,
`ifdef OUTARB_OVERRIDE_EN
   input  logic [NUM_IN-1:0]        override_oth,
`endif
   output logic [CNT_W-1:0]         credits
);

   localparam int               c_idx_w = $clog2(NUM_IN);
   localparam logic [CNT_W-1:0] c_full  = CNT_W'(CREDITS);

   arb_state_t          r_state,   w_state_nxt;
   logic [c_idx_w-1:0]  r_owner,   w_owner_nxt;
   logic [c_idx_w-1:0]  r_rr_ptr,  w_rr_ptr_nxt;
   logic [CNT_W-1:0]    r_credits, w_credits_nxt;
   logic [DATA_W-1:0]   r_q;
   logic                r_send;

   logic [NUM_IN-1:0]   w_rr_oh;
   logic [c_idx_w-1:0]  w_rr_idx;
   logic                w_rr_valid;

   logic [NUM_IN-1:0]   w_win_oh;
   logic [c_idx_w-1:0]  w_win_idx;
   logic                w_win_valid;
   logic                w_win_tail;
   logic                w_accept;

   logic [c_idx_w-1:0]  w_ovr_idx;
   logic                w_ovr_valid;

   rr_arbiter #(
      .N     (NUM_IN),
      .IDX_W (c_idx_w)
   ) u_rr (
      .req       (req),
      .ptr       (r_rr_ptr),
      .win_oh    (w_rr_oh),
      .win_idx   (w_rr_idx),
      .win_valid (w_rr_valid)
   );

`ifdef OUTARB_OVERRIDE_EN
   logic [NUM_IN-1:0] w_ovr_req;
   assign w_ovr_req = override_oth & req;

   // Descending scan so the lowest set index is the last one written.
   always_comb begin
      w_ovr_idx   = '0;
      w_ovr_valid = 1'b0;
      for (int i = NUM_IN - 1; i >= 0; i--) begin
         if (w_ovr_req[i]) begin
            w_ovr_valid = 1'b1;
            w_ovr_idx   = c_idx_w'(i);
         end
      end
   end
`else
   assign w_ovr_idx   = '0;
   assign w_ovr_valid = 1'b0;
`endif

   // Winner selection: the lock owner excludes everyone else; override only
   // applies between packets.
   always_comb begin
      w_win_oh    = w_rr_oh;
      w_win_idx   = w_rr_idx;
      w_win_valid = w_rr_valid;
      if (r_state == ST_LOCKED) begin
         w_win_idx   = r_owner;
         w_win_valid = req[r_owner];
         w_win_oh    = NUM_IN'(1) << r_owner;
      end else if (w_ovr_valid) begin
         w_win_idx   = w_ovr_idx;
         w_win_valid = 1'b1;
         w_win_oh    = NUM_IN'(1) << w_ovr_idx;
      end
   end

   assign w_accept   = (r_credits != '0) && w_win_valid;
   assign w_win_tail = tail[w_win_idx];
   assign grant      = w_accept ? w_win_oh : '0;

   // Next-state: lock on a non-tail head, release and advance the pointer
   // past the sender on a tail. Bubbles and credit stalls change nothing.
   always_comb begin
      w_state_nxt  = r_state;
      w_owner_nxt  = r_owner;
      w_rr_ptr_nxt = r_rr_ptr;
      if (w_accept) begin
         if (w_win_tail) begin
            w_state_nxt  = ST_IDLE;
            w_rr_ptr_nxt = c_idx_w'(wrap_inc(int'(w_win_idx), NUM_IN));
         end else begin
            w_state_nxt = ST_LOCKED;
            w_owner_nxt = w_win_idx;
         end
      end
   end

   // Credit counter; a return at full saturates instead of wrapping.
   always_comb begin
      w_credits_nxt = r_credits;
      case ({w_accept, credit_ret})
         2'b10:   w_credits_nxt = r_credits - 1'b1;
         2'b01:   if (r_credits != c_full) w_credits_nxt = r_credits + 1'b1;
         default: w_credits_nxt = r_credits;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= ST_IDLE;
         r_owner   <= '0;
         r_rr_ptr  <= '0;
         r_credits <= c_full;
         r_q       <= '0;
         r_send    <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_owner   <= w_owner_nxt;
         r_rr_ptr  <= w_rr_ptr_nxt;
         r_credits <= w_credits_nxt;
         r_send    <= w_accept;
         if (w_accept) begin
            r_q <= iput[int'(w_win_idx)*DATA_W +: DATA_W];
         end
      end
   end

   assign q       = r_q;
   assign send    = r_send;
   assign credits = r_credits;

`ifndef SYNTHESIS
   a_credit_overflow: assert property (@(posedge clk) disable iff (rst)
      !(credit_ret && (r_credits == c_full)));
`endif

endmodule
`default_nettype wire

// File: tb/tb_outport_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_outport_arbiter
//  Description : Self-checking bench for outport_arbiter (default parameters:
//                5 inputs, 33-bit flits, 4 credits). Expected grants and
//                credit counts come from per-scenario tables; flits granted
//                are pushed to a scoreboard and popped when send rises.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_outport_arbiter;

   localparam int NUM_IN = 5;
   localparam int DATA_W = 33;
   localparam int CNT_W  = 3;

   logic                     clk = 1'b0;
   logic                     rst;
   logic [NUM_IN-1:0]        req;
   logic [NUM_IN-1:0]        tail;
   logic [NUM_IN*DATA_W-1:0] iput;
   logic [NUM_IN-1:0]        grant;
   logic [DATA_W-1:0]        q;
   logic                     send;
   logic                     credit_ret;
   logic [NUM_IN-1:0]        override_oth;
   logic [CNT_W-1:0]         credits;

   int n_checks = 0;
   int n_fail   = 0;
   int seq      = 0;
   logic [DATA_W-1:0] sb [$];

   always #5 clk = ~clk;

   outport_arbiter #(
      .NUM_IN  (NUM_IN),
      .DATA_W  (DATA_W),
      .CREDITS (4),
      .CNT_W   (CNT_W)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .req          (req),
      .tail         (tail),
      .iput         (iput),
      .grant        (grant),
      .q            (q),
      .send         (send),
      .credit_ret   (credit_ret),
`ifdef OUTARB_OVERRIDE_EN
      .override_oth (override_oth),
`endif
      .credits      (credits)
   );

   function automatic logic [DATA_W-1:0] flit_val(input int i, input int s);
      return DATA_W'(s * 256 + i + 17);
   endfunction

   function automatic int idx_of(input logic [NUM_IN-1:0] oh);
      int r;
      r = 0;
      for (int i = 0; i < NUM_IN; i++) if (oh[i]) r = i;
      return r;
   endfunction

   task automatic set_flits();
      for (int i = 0; i < NUM_IN; i++) iput[i*DATA_W +: DATA_W] = flit_val(i, seq);
   endtask

   task automatic do_reset();
      rst = 1'b1; req = '0; tail = '0; credit_ret = 1'b0; override_oth = '0;
      set_flits();
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      sb.delete();
   endtask

   task automatic test_reset();
      do_reset();
      n_checks++;
      if (credits !== 3'd4) begin n_fail++; $display("FAIL reset_credits: got %0d expected 4", credits); end
      n_checks++;
      if (send !== 1'b0) begin n_fail++; $display("FAIL reset_send: got %b expected 0", send); end
      n_checks++;
      if (q !== '0) begin n_fail++; $display("FAIL reset_q: got %h expected 0", q); end
      n_checks++;
      if (grant !== '0) begin n_fail++; $display("FAIL reset_grant: got %b expected 0", grant); end
   endtask

   // All single-flit packets from inputs 0,1,4; credits run out after four.
   task automatic test_round_robin();
      logic [4:0] t_req [8];
      logic [4:0] t_gnt [8];
      logic       t_ret [8];
      logic [2:0] t_crd [8];
      logic exp_send;
      logic [DATA_W-1:0] exp_q;
      do_reset();
      t_req = '{5'b10011, 5'b10011, 5'b10011, 5'b10011, 5'b10011, 5'b10011, 5'b10011, 5'b00000};
      t_gnt = '{5'b00001, 5'b00010, 5'b10000, 5'b00001, 5'b00000, 5'b00000, 5'b00010, 5'b00000};
      t_ret = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
      t_crd = '{3'd4, 3'd3, 3'd2, 3'd1, 3'd0, 3'd0, 3'd1, 3'd0};
      exp_send = 1'b0;
      for (int c = 0; c < 8; c++) begin
         n_checks++;
         if (send !== exp_send) begin n_fail++; $display("FAIL rr_send c%0d: got %b expected %b", c, send, exp_send); end
         if (exp_send) begin
            exp_q = sb.pop_front();
            n_checks++;
            if (q !== exp_q) begin n_fail++; $display("FAIL rr_q c%0d: got %h expected %h", c, q, exp_q); end
         end
         n_checks++;
         if (credits !== t_crd[c]) begin n_fail++; $display("FAIL rr_credits c%0d: got %0d expected %0d", c, credits, t_crd[c]); end
         req = t_req[c]; tail = 5'b11111; credit_ret = t_ret[c];
         set_flits();
         #1;
         n_checks++;
         if (grant !== t_gnt[c]) begin n_fail++; $display("FAIL rr_grant c%0d: got %b expected %b", c, grant, t_gnt[c]); end
         exp_send = (t_gnt[c] != 5'b0);
         if (exp_send) sb.push_back(flit_val(idx_of(t_gnt[c]), seq));
         seq++;
         @(posedge clk); #1;
      end
   endtask

   // 3-flit packet on input 2 with a bubble; input 0 keeps requesting.
   task automatic test_wormhole();
      logic [4:0] t_req  [8];
      logic [4:0] t_tail [8];
      logic [4:0] t_gnt  [8];
      logic       t_ret  [8];
      logic [2:0] t_crd  [8];
      logic exp_send;
      logic [DATA_W-1:0] exp_q;
      do_reset();
      t_req  = '{5'b00010, 5'b00101, 5'b00001, 5'b00101, 5'b00101, 5'b01001, 5'b00001, 5'b00000};
      t_tail = '{5'b00010, 5'b00001, 5'b00001, 5'b00001, 5'b00101, 5'b01001, 5'b00001, 5'b00000};
      t_gnt  = '{5'b00010, 5'b00100, 5'b00000, 5'b00100, 5'b00100, 5'b01000, 5'b00001, 5'b00000};
      t_ret  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
      t_crd  = '{3'd4, 3'd3, 3'd3, 3'd4, 3'd3, 3'd3, 3'd3, 3'd3};
      exp_send = 1'b0;
      for (int c = 0; c < 8; c++) begin
         n_checks++;
         if (send !== exp_send) begin n_fail++; $display("FAIL wh_send c%0d: got %b expected %b", c, send, exp_send); end
         if (exp_send) begin
            exp_q = sb.pop_front();
            n_checks++;
            if (q !== exp_q) begin n_fail++; $display("FAIL wh_q c%0d: got %h expected %h", c, q, exp_q); end
         end
         n_checks++;
         if (credits !== t_crd[c]) begin n_fail++; $display("FAIL wh_credits c%0d: got %0d expected %0d", c, credits, t_crd[c]); end
         req = t_req[c]; tail = t_tail[c]; credit_ret = t_ret[c];
         set_flits();
         #1;
         n_checks++;
         if (grant !== t_gnt[c]) begin n_fail++; $display("FAIL wh_grant c%0d: got %b expected %b", c, grant, t_gnt[c]); end
         exp_send = (t_gnt[c] != 5'b0);
         if (exp_send) sb.push_back(flit_val(idx_of(t_gnt[c]), seq));
         seq++;
         @(posedge clk); #1;
      end
      credit_ret = 1'b0;
   endtask

   // Exhaustion, credit-return loop and simultaneous accept + return at 2.
   task automatic test_credit_edges();
      logic [4:0] t_req [11];
      logic [4:0] t_gnt [11];
      logic       t_ret [11];
      logic [2:0] t_crd [11];
      logic exp_send;
      logic [DATA_W-1:0] exp_q;
      do_reset();
      t_req = '{5'b00001, 5'b00001, 5'b00001, 5'b00001, 5'b00001, 5'b00000,
                5'b00001, 5'b00000, 5'b00000, 5'b00001, 5'b00000};
      t_gnt = '{5'b00001, 5'b00001, 5'b00001, 5'b00001, 5'b00000, 5'b00000,
                5'b00001, 5'b00000, 5'b00000, 5'b00001, 5'b00000};
      t_ret = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
      t_crd = '{3'd4, 3'd3, 3'd2, 3'd1, 3'd0, 3'd0, 3'd1, 3'd0, 3'd1, 3'd2, 3'd2};
      exp_send = 1'b0;
      for (int c = 0; c < 11; c++) begin
         n_checks++;
         if (send !== exp_send) begin n_fail++; $display("FAIL cr_send c%0d: got %b expected %b", c, send, exp_send); end
         if (exp_send) begin
            exp_q = sb.pop_front();
            n_checks++;
            if (q !== exp_q) begin n_fail++; $display("FAIL cr_q c%0d: got %h expected %h", c, q, exp_q); end
         end
         n_checks++;
         if (credits !== t_crd[c]) begin n_fail++; $display("FAIL cr_credits c%0d: got %0d expected %0d", c, credits, t_crd[c]); end
         req = t_req[c]; tail = 5'b11111; credit_ret = t_ret[c];
         set_flits();
         #1;
         n_checks++;
         if (grant !== t_gnt[c]) begin n_fail++; $display("FAIL cr_grant c%0d: got %b expected %b", c, grant, t_gnt[c]); end
         exp_send = (t_gnt[c] != 5'b0);
         if (exp_send) sb.push_back(flit_val(idx_of(t_gnt[c]), seq));
         seq++;
         @(posedge clk); #1;
      end
   endtask

`ifdef OUTARB_OVERRIDE_EN
   // Override wins in IDLE, is ignored while locked to input 1.
   task automatic test_override();
      logic [4:0] t_req  [5];
      logic [4:0] t_tail [5];
      logic [4:0] t_ovr  [5];
      logic [4:0] t_gnt  [5];
      logic [2:0] t_crd  [5];
      logic exp_send;
      logic [DATA_W-1:0] exp_q;
      do_reset();
      t_req  = '{5'b00001, 5'b01110, 5'b00010, 5'b01010, 5'b00000};
      t_tail = '{5'b00001, 5'b11111, 5'b00000, 5'b00000, 5'b00000};
      t_ovr  = '{5'b00000, 5'b01000, 5'b00000, 5'b01000, 5'b00000};
      t_gnt  = '{5'b00001, 5'b01000, 5'b00010, 5'b00010, 5'b00000};
      t_crd  = '{3'd4, 3'd3, 3'd2, 3'd1, 3'd0};
      exp_send = 1'b0;
      for (int c = 0; c < 5; c++) begin
         n_checks++;
         if (send !== exp_send) begin n_fail++; $display("FAIL ov_send c%0d: got %b expected %b", c, send, exp_send); end
         if (exp_send) begin
            exp_q = sb.pop_front();
            n_checks++;
            if (q !== exp_q) begin n_fail++; $display("FAIL ov_q c%0d: got %h expected %h", c, q, exp_q); end
         end
         n_checks++;
         if (credits !== t_crd[c]) begin n_fail++; $display("FAIL ov_credits c%0d: got %0d expected %0d", c, credits, t_crd[c]); end
         req = t_req[c]; tail = t_tail[c]; override_oth = t_ovr[c]; credit_ret = 1'b0;
         set_flits();
         #1;
         n_checks++;
         if (grant !== t_gnt[c]) begin n_fail++; $display("FAIL ov_grant c%0d: got %b expected %b", c, grant, t_gnt[c]); end
         exp_send = (t_gnt[c] != 5'b0);
         if (exp_send) sb.push_back(flit_val(idx_of(t_gnt[c]), seq));
         seq++;
         @(posedge clk); #1;
      end
      override_oth = '0;
   endtask
`endif

   // Reset while locked to input 2 must free the port for input 0.
   task automatic test_mid_reset();
      logic [DATA_W-1:0] exp_q;
      do_reset();
      for (int c = 0; c < 2; c++) begin
         req = 5'b00100; tail = 5'b00000;
         set_flits();
         #1;
         n_checks++;
         if (grant !== 5'b00100) begin n_fail++; $display("FAIL mr_grant c%0d: got %b expected 00100", c, grant); end
         sb.push_back(flit_val(2, seq));
         seq++;
         @(posedge clk); #1;
         exp_q = sb.pop_front();
         n_checks++;
         if (send !== 1'b1 || q !== exp_q) begin
            n_fail++; $display("FAIL mr_out c%0d: got send=%b q=%h expected send=1 q=%h", c, send, q, exp_q);
         end
      end
      rst = 1'b1; req = 5'b00001; tail = 5'b00001;
      @(posedge clk); #1;
      rst = 1'b0;
      sb.delete();
      n_checks++;
      if (send !== 1'b0) begin n_fail++; $display("FAIL mr_send: got %b expected 0", send); end
      n_checks++;
      if (credits !== 3'd4) begin n_fail++; $display("FAIL mr_credits: got %0d expected 4", credits); end
      n_checks++;
      if (q !== '0) begin n_fail++; $display("FAIL mr_q: got %h expected 0", q); end
      set_flits();
      #1;
      n_checks++;
      if (grant !== 5'b00001) begin n_fail++; $display("FAIL mr_unlock_grant: got %b expected 00001", grant); end
      exp_q = flit_val(0, seq);
      seq++;
      @(posedge clk); #1;
      n_checks++;
      if (send !== 1'b1 || q !== exp_q) begin
         n_fail++; $display("FAIL mr_unlock_out: got send=%b q=%h expected send=1 q=%h", send, q, exp_q);
      end
      req = '0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_round_robin();
      test_wormhole();
      test_credit_edges();
`ifdef OUTARB_OVERRIDE_EN
      test_override();
`endif
      test_mid_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
